imm_encoder: RTL and testbench

Immediate packer for the single-cycle RISC-V core's instruction-generation path. It is the inverse of the immediate sign-extend/decode stage. It takes a base instruction word with its non-immediate fields already set, a signed 32-bit immediate and an ImmSrc code, then scatters the immediate into the I-, S- or B-format bit positions. The block is a 2-stage valid/ready pipeline with optional range checking and running output/error counters. It feeds the instruction-memory loader and the self-check test generators.

---
 rtl/imm_pkg.sv | 36 +++
 rtl/imm_pack.sv | 51 +++++
 rtl/imm_encoder.sv | 111 +++++++++++
 tb/tb_imm_encoder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared ImmSrc encodings, field positions and instruction type
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_I   = 2'b00,
    IMM_S   = 2'b01,
    IMM_B   = 2'b10,
    IMM_BAD = 2'b11
  } imm_src_e;

  typedef logic [31:0] instr_t;

  localparam int I_IMM_LSB  = 20;
  localparam int S_HI_LSB   = 25;
  localparam int S_LO_LSB   = 7;
  localparam int B_SIGN_BIT = 31;
  localparam int B_HI_LSB   = 25;
  localparam int B_LO_LSB   = 8;
  localparam int B_B11_BIT  = 7;

  // True when v[31:msb] are all equal, i.e. v fits a signed (msb+1)-bit field.
  function automatic logic fits_signed(input logic [31:0] v, input int msb);
    logic all1;
    logic all0;
    all1 = 1'b1;
    all0 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k >= msb) begin
        all1 = all1 & v[k];
        all0 = all0 & ~v[k];
      end
    end
    return all1 | all0;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational immediate scatter into I/S/B fields (range check: IMM_ENC_RANGE_CHECK_EN)
module imm_pack
  import imm_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [1:0]  imm_src,
  output instr_t      instr,
  output logic        err
);

  logic bad_src;
  logic range_err;

  always_comb begin
    instr     = base;
    bad_src   = 1'b0;
    range_err = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_I: begin
        instr[I_IMM_LSB +: 12] = imm[11:0];
        range_err = !fits_signed(imm, 11);
      end
      IMM_S: begin
        instr[S_HI_LSB +: 7] = imm[11:5];
        instr[S_LO_LSB +: 5] = imm[4:0];
        range_err = !fits_signed(imm, 11);
      end
      IMM_B: begin
        instr[B_SIGN_BIT]    = imm[12];
        instr[B_HI_LSB +: 6] = imm[10:5];
        instr[B_LO_LSB +: 4] = imm[4:1];
        instr[B_B11_BIT]     = imm[11];
        // Branch offsets are halfword aligned; an odd offset cannot be encoded.
        range_err = !fits_signed(imm, 12) || imm[0];
      end
      IMM_BAD: begin
        bad_src = 1'b1;
      end
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  assign err = bad_src | range_err;
`else
  logic unused_range_err;
  assign unused_range_err = range_err;
  assign err = bad_src;
`endif

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - 2-stage valid/ready immediate packer with output/error counters (IMM_ENC_RANGE_CHECK_EN)
module imm_encoder
  import imm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [1:0]  ImmSrc,
  output logic        out_valid,
  input  logic        out_ready,
  output instr_t      Instr,
  output logic        err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  instr_t      pack_instr;
  logic        pack_err;
  logic        s1_adv;
  logic        accept;
  logic        out_fire;

  logic        s1_valid_q, s1_valid_d;
  instr_t      s1_instr_q, s1_instr_d;
  logic        s1_err_q,   s1_err_d;
  logic        s2_valid_q, s2_valid_d;
  instr_t      s2_instr_q, s2_instr_d;
  logic        s2_err_q,   s2_err_d;
  logic [15:0] enc_count_q, enc_count_d;
  logic [7:0]  err_count_q, err_count_d;

  imm_pack u_pack (
    .base    (base),
    .imm     (imm),
    .imm_src (ImmSrc),
    .instr   (pack_instr),
    .err     (pack_err)
  );

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_instr_d  = s1_instr_q;
    s1_err_d    = s1_err_q;
    s2_valid_d  = s2_valid_q;
    s2_instr_d  = s2_instr_q;
    s2_err_d    = s2_err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;

    // S2 data only changes when a real entry moves in, so Instr holds under stall.
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = s1_instr_q;
        s2_err_d   = s1_err_q;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_instr_d = pack_instr;
      s1_err_d   = pack_err;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (out_fire) begin
      enc_count_d = enc_count_q + 16'd1;
      if (s2_err_q && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_instr_q  <= '0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= '0;
      s2_err_q    <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_instr_q  <= s1_instr_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign Instr     = s2_instr_q;
  assign err       = s2_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder (honours IMM_ENC_RANGE_CHECK_EN)
module tb_imm_encoder;

`ifdef IMM_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base;
  logic [31:0] imm;
  logic [1:0]  ImmSrc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .base      (base),
    .imm       (imm),
    .ImmSrc    (ImmSrc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Instr     (Instr),
    .err       (err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] instr;
    logic        err_rc;
    logic        err_norc;
  } vec_t;

  vec_t        vecs[14];
  logic [32:0] sb_q[$];
  logic [32:0] mon_e;
  int          checks;
  int          failures;
  int          exp_enc;
  int          exp_err;
  bit          toggling;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] b, input logic [31:0] i, input logic [1:0] s,
                      input logic [31:0] ei, input logic ee);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    base     = b;
    imm      = i;
    ImmSrc   = s;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end else begin
      sb_q.push_back({ei, ee});
    end
    @(posedge clk);
  endtask

  task automatic send_vec(input int k);
    send(vecs[k].base, vecs[k].imm, vecs[k].src, vecs[k].instr, RC ? vecs[k].err_rc : vecs[k].err_norc);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
    end
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    sb_q.delete();
    exp_enc = 0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic latency_test(input string tag);
    send_vec(0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_ovalid_edge1"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_ovalid_edge2"}, {31'b0, out_valid}, 32'd1);
    drain();
  endtask

  // Scoreboard monitor: samples mid-cycle, after the driver has settled inputs.
  always @(negedge clk) begin
    #2;
    if (rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h required=no_output", Instr);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_instr", Instr, mon_e[32:1]);
        chk("out_err", {31'b0, err}, {31'b0, mon_e[0]});
        exp_enc = (exp_enc + 1) % 65536;
        if (mon_e[0] && exp_err != 255) exp_err++;
      end
    end
  end

  always @(negedge clk) begin
    if (toggling) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks    = 0;
    failures  = 0;
    exp_enc   = 0;
    exp_err   = 0;
    toggling  = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    base      = '0;
    imm       = '0;
    ImmSrc    = '0;

    vecs[0]  = '{32'h00002003, 32'hFFFFFFFC, 2'b00, 32'hFFC02003, 1'b0, 1'b0};
    vecs[1]  = '{32'h00002023, 32'h00000008, 2'b01, 32'h00002423, 1'b0, 1'b0};
    vecs[2]  = '{32'h00000063, 32'hFFFFFFF8, 2'b10, 32'hFE000CE3, 1'b0, 1'b0};
    vecs[3]  = '{32'h00000013, 32'h00000800, 2'b00, 32'h80000013, 1'b1, 1'b0};
    vecs[4]  = '{32'h00000063, 32'h00000003, 2'b10, 32'h00000163, 1'b1, 1'b0};
    vecs[5]  = '{32'h12345678, 32'h00000005, 2'b11, 32'h12345678, 1'b1, 1'b1};
    vecs[6]  = '{32'h00002023, 32'hFFFFFFFC, 2'b01, 32'hFE002E23, 1'b0, 1'b0};
    vecs[7]  = '{32'h00000013, 32'h000007FF, 2'b00, 32'h7FF00013, 1'b0, 1'b0};
    vecs[8]  = '{32'h00000013, 32'hFFFFF800, 2'b00, 32'h80000013, 1'b0, 1'b0};
    vecs[9]  = '{32'h00002023, 32'h00001000, 2'b01, 32'h00002023, 1'b1, 1'b0};
    vecs[10] = '{32'h00000063, 32'h00000FFE, 2'b10, 32'h7E000FE3, 1'b0, 1'b0};
    vecs[11] = '{32'h00000063, 32'h00001000, 2'b10, 32'h80000063, 1'b1, 1'b0};
    vecs[12] = '{32'h00000063, 32'hFFFFF000, 2'b10, 32'h80000063, 1'b0, 1'b0};
    vecs[13] = '{32'hFFFFFFFF, 32'h00000000, 2'b00, 32'h000FFFFF, 1'b0, 1'b0};

    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_enc_count", {16'b0, enc_count}, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    latency_test("lat");

    for (int k = 0; k < 14; k++) send_vec(k);
    idle();
    drain();
    chk("tbl_enc_count", {16'b0, enc_count}, 32'd15);
    chk("tbl_err_count", {24'b0, err_count}, RC ? 32'd5 : 32'd1);

    toggling = 1'b1;
    for (int k = 0; k < 14; k++) send_vec(k);
    idle();
    toggling  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("bp_rand_enc_count", {16'b0, enc_count}, 32'd29);
    chk("bp_rand_err_count", {24'b0, err_count}, RC ? 32'd10 : 32'd2);
    chk("bp_rand_enc_model", {16'b0, enc_count}, exp_enc);

    apply_reset();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; base = vecs[0].base; imm = vecs[0].imm; ImmSrc = vecs[0].src;
    #1;
    chk("bp_ready_a", {31'b0, in_ready}, 32'd1);
    sb_q.push_back({vecs[0].instr, 1'b0});
    @(posedge clk);
    @(negedge clk);
    base = vecs[1].base; imm = vecs[1].imm; ImmSrc = vecs[1].src;
    #1;
    chk("bp_ready_b", {31'b0, in_ready}, 32'd1);
    sb_q.push_back({vecs[1].instr, 1'b0});
    @(posedge clk);
    @(negedge clk);
    base = vecs[2].base; imm = vecs[2].imm; ImmSrc = vecs[2].src;
    #1;
    chk("bp_ready_full", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_instr", Instr, vecs[0].instr);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", {31'b0, in_ready}, 32'd1);
    sb_q.push_back({vecs[2].instr, 1'b0});
    @(posedge clk);
    idle();
    drain();
    chk("bp_enc_count", {16'b0, enc_count}, 32'd3);

    apply_reset();
    for (int k = 0; k < 65537; k++) send_vec(7);
    idle();
    drain();
    chk("wrap_enc_count", {16'b0, enc_count}, 32'd1);
    chk("wrap_err_count", {24'b0, err_count}, 32'd0);
    for (int k = 0; k < 300; k++) send_vec(5);
    idle();
    drain();
    chk("sat_err_count", {24'b0, err_count}, 32'h000000FF);
    chk("sat_enc_count", {16'b0, enc_count}, 32'd301);

    out_ready = 1'b0;
    send_vec(1);
    send_vec(2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_full_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_enc_count", {16'b0, enc_count}, 32'd0);
    chk("mid_rst_err_count", {24'b0, err_count}, 32'd0);
    sb_q.delete();
    exp_enc = 0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_in_ready", {31'b0, in_ready}, 32'd1);
    latency_test("post");
    chk("post_enc_count", {16'b0, enc_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
